// File: rtl/axi_rd_nsaid_arbiter.sv
// AXI4 read-path arbiter: round-robin AR grant stamped with the requester NSAID, R routed back
// through an in-flight ID table. Optional per-requester stall counters: AXI_RD_ARB_PERF_EN.

package axi_rd_nsaid_pkg;
  localparam int unsigned IdW = 4;
  typedef logic [IdW-1:0] id_t;

  typedef struct packed {
    id_t         id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_chan_t;

  typedef struct packed {
    id_t         id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  nsaid;
  } ar_chan_nsaid_t;

  typedef struct packed {
    id_t         id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;
endpackage

module axi_rd_nsaid_arbiter
  import axi_rd_nsaid_pkg::*;
#(
  parameter int unsigned NumMst   = 4,
  parameter int unsigned IdWidth  = IdW,
  parameter int unsigned MaxTxn   = 8,
  parameter int unsigned CntWidth = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  ar_chan_t [NumMst-1:0]      mst_ar_i,
  input  logic [NumMst-1:0]          mst_ar_valid_i,
  output logic [NumMst-1:0]          mst_ar_ready_o,
  output r_chan_t [NumMst-1:0]       mst_r_o,
  output logic [NumMst-1:0]          mst_r_valid_o,
  input  logic [NumMst-1:0]          mst_r_ready_i,
  input  logic [NumMst-1:0][3:0]     nsaid_cfg_i,
  output ar_chan_nsaid_t             slv_ar_o,
  output logic                       slv_ar_valid_o,
  input  logic                       slv_ar_ready_i,
  input  r_chan_t                    slv_r_i,
  input  logic                       slv_r_valid_i,
  output logic                       slv_r_ready_o,
  output logic                       err_o
`ifdef AXI_RD_ARB_PERF_EN
  ,
  output logic [NumMst-1:0][CntWidth-1:0] perf_stall_o
`endif
);

  localparam int unsigned MstW   = (NumMst > 1) ? $clog2(NumMst) : 1;
  localparam int unsigned CntW   = $clog2(MaxTxn + 1);
  localparam int unsigned NumIds = 2 ** IdWidth;

  if (NumMst < 2 || NumMst > 8 || IdWidth != IdW || CntWidth < 1) begin : g_bad_param
    $error("axi_rd_nsaid_arbiter: unsupported parameter set");
  end

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_e;

  state_e              state_r, state_s;
  logic [MstW-1:0]     rr_ptr_r, lock_idx_r, pick_s, grant_idx_s, idx_s;
  logic [MstW:0]       cand_s;
  logic [3:0]          nsaid_r, nsaid_s;
  logic                pick_vld_s, ar_vld_s, ar_hs_s, err_r;
  logic [NumMst-1:0]   eligible_s;
  id_t                 ar_id_s, r_id_s;
  logic                r_hit_s, r_last_hs_s, r_drop_s;
  logic [MstW-1:0]     r_owner_s;
  logic [NumIds-1:0]   tbl_inc_s, tbl_dec_s;
  logic                tbl_valid_r [NumIds];
  logic [MstW-1:0]     tbl_owner_r [NumIds];
  logic [CntW-1:0]     tbl_cnt_r   [NumIds];

  // Requester eligibility: its ID is free, or already its own and not full
  always_comb begin
    eligible_s = '0;
    for (int m = 0; m < NumMst; m++) begin
      eligible_s[m] = mst_ar_valid_i[m] &
                      (~tbl_valid_r[mst_ar_i[m].id] |
                       ((tbl_owner_r[mst_ar_i[m].id] == MstW'(m)) &
                        (tbl_cnt_r[mst_ar_i[m].id] < CntW'(MaxTxn))));
    end
  end

  // Round-robin pick; scanning downwards lets the lowest offset from rr_ptr win
  always_comb begin
    pick_s = '0;
    cand_s = '0;
    idx_s  = '0;
    for (int i = NumMst - 1; i >= 0; i--) begin
      cand_s = {1'b0, rr_ptr_r} + (MstW+1)'(i);
      if (cand_s >= (MstW+1)'(NumMst)) begin
        idx_s = MstW'(cand_s - (MstW+1)'(NumMst));
      end else begin
        idx_s = cand_s[MstW-1:0];
      end
      pick_s = eligible_s[idx_s] ? idx_s : pick_s;
    end
    pick_vld_s = |eligible_s;
  end

  // Grant selection and AR handshake; LOCKED holds requester and NSAID until accepted
  always_comb begin
    ar_vld_s    = 1'b0;
    grant_idx_s = pick_s;
    nsaid_s     = nsaid_cfg_i[pick_s];
    case (state_r)
      ST_IDLE: begin
        ar_vld_s    = pick_vld_s;
        grant_idx_s = pick_s;
        nsaid_s     = nsaid_cfg_i[pick_s];
      end
      ST_LOCKED: begin
        ar_vld_s    = 1'b1;
        grant_idx_s = lock_idx_r;
        nsaid_s     = nsaid_r;
      end
      default: begin
        ar_vld_s    = 1'b0;
        grant_idx_s = '0;
        nsaid_s     = 4'd0;
      end
    endcase
    ar_vld_s       = ar_vld_s & ~rst_i;
    ar_hs_s        = ar_vld_s & slv_ar_ready_i;
    mst_ar_ready_o = '0;
    if (ar_hs_s) begin
      mst_ar_ready_o[grant_idx_s] = 1'b1;
      state_s = ST_IDLE;
    end else if (ar_vld_s) begin
      state_s = ST_LOCKED;
    end else begin
      state_s = ST_IDLE;
    end
    ar_id_s         = mst_ar_i[grant_idx_s].id;
    slv_ar_o.id     = mst_ar_i[grant_idx_s].id;
    slv_ar_o.addr   = mst_ar_i[grant_idx_s].addr;
    slv_ar_o.len    = mst_ar_i[grant_idx_s].len;
    slv_ar_o.size   = mst_ar_i[grant_idx_s].size;
    slv_ar_o.burst  = mst_ar_i[grant_idx_s].burst;
    slv_ar_o.nsaid  = nsaid_s;
    slv_ar_valid_o  = ar_vld_s;
  end

  // R routing by table lookup; unknown IDs are sunk and flagged
  always_comb begin
    r_id_s        = slv_r_i.id;
    r_hit_s       = tbl_valid_r[r_id_s];
    r_owner_s     = tbl_owner_r[r_id_s];
    mst_r_valid_o = '0;
    if (slv_r_valid_i && !rst_i) begin
      if (r_hit_s) begin
        mst_r_valid_o[r_owner_s] = 1'b1;
        slv_r_ready_o            = mst_r_ready_i[r_owner_s];
      end else begin
        slv_r_ready_o = 1'b1;
      end
    end else begin
      slv_r_ready_o = 1'b0;
    end
    r_last_hs_s = slv_r_valid_i & ~rst_i & r_hit_s & slv_r_ready_o & slv_r_i.last;
    r_drop_s    = slv_r_valid_i & ~rst_i & ~r_hit_s;
    tbl_inc_s   = ar_hs_s ? (NumIds'(1) << ar_id_s) : '0;
    tbl_dec_s   = r_last_hs_s ? (NumIds'(1) << r_id_s) : '0;
  end

  assign mst_r_o = {NumMst{slv_r_i}};
  assign err_o   = err_r;

  // Arbiter state, round-robin pointer, locked NSAID and sticky error
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      rr_ptr_r   <= '0;
      lock_idx_r <= '0;
      nsaid_r    <= 4'd0;
      err_r      <= 1'b0;
    end else begin
      state_r <= state_s;
      if (ar_hs_s) begin
        rr_ptr_r <= (grant_idx_s == MstW'(NumMst - 1)) ? '0 : grant_idx_s + MstW'(1);
      end
      if (ar_vld_s && !ar_hs_s && state_r == ST_IDLE) begin
        lock_idx_r <= pick_s;
        nsaid_r    <= nsaid_cfg_i[pick_s];
      end
      if (r_drop_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // In-flight ID table; a simultaneous issue and retire on one ID cancel out
  always_ff @(posedge clk_i) begin
    for (int e = 0; e < NumIds; e++) begin
      if (rst_i) begin
        tbl_valid_r[e] <= 1'b0;
        tbl_owner_r[e] <= '0;
        tbl_cnt_r[e]   <= '0;
      end else if (tbl_inc_s[e] && !tbl_dec_s[e]) begin
        tbl_valid_r[e] <= 1'b1;
        tbl_owner_r[e] <= grant_idx_s;
        tbl_cnt_r[e]   <= tbl_cnt_r[e] + CntW'(1);
      end else if (tbl_dec_s[e] && !tbl_inc_s[e]) begin
        tbl_valid_r[e] <= (tbl_cnt_r[e] != CntW'(1));
        tbl_cnt_r[e]   <= tbl_cnt_r[e] - CntW'(1);
      end
    end
  end

`ifdef AXI_RD_ARB_PERF_EN
  logic [NumMst-1:0][CntWidth-1:0] perf_stall_r;

  // Saturating per-requester stall cycle counters
  always_ff @(posedge clk_i) begin
    for (int m = 0; m < NumMst; m++) begin
      if (rst_i) begin
        perf_stall_r[m] <= '0;
      end else if (mst_ar_valid_i[m] && !mst_ar_ready_o[m] && (perf_stall_r[m] != '1)) begin
        perf_stall_r[m] <= perf_stall_r[m] + CntWidth'(1);
      end
    end
  end

  assign perf_stall_o = perf_stall_r;
`endif

endmodule

// File: doc/axi_rd_nsaid_arbiter.md
Name: axi_rd_nsaid_arbiter

Overview:
- Shares one AXI4 read path (AR/R) between NumMst requesters in front of the IOPMP.
- AR uses round-robin arbitration. Each granted request is stamped with that requester's NSAID and sent out as an ar_chan_nsaid_t.
- R beats go back to the originating requester through an in-flight ID table.
- The ID table blocks ID collisions between requesters, so the slave-side ID keeps its id_t width.

Parameters:
- NumMst, 4, number of requesters (2..8).
- IdWidth, 4, AR/R ID width (matches id_t).
- MaxTxn, 8, maximum outstanding reads per ID.
- CntWidth, 32, perf counter width (optional feature only).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- mst_ar_i  in  NumMst x ar_chan_t  requester AR payloads.
- mst_ar_valid_i  in  NumMst  AR valid per requester.
- mst_ar_ready_o  out  NumMst  AR ready per requester.
- mst_r_o  out  NumMst x r_chan_t  R payloads to requesters (all carry the slave beat).
- mst_r_valid_o  out  NumMst  R valid per requester.
- mst_r_ready_i  in  NumMst  R ready per requester.
- nsaid_cfg_i  in  NumMst x 4  NSAID per requester; sampled at grant.
- slv_ar_o  out  ar_chan_nsaid_t  arbitrated AR with nsaid.
- slv_ar_valid_o  out  1  slave AR valid.
- slv_ar_ready_i  in  1  slave AR ready.
- slv_r_i  in  r_chan_t  slave R beat.
- slv_r_valid_i  in  1  slave R valid.
- slv_r_ready_o  out  1  slave R ready.
- err_o  out  1  sticky flag: R beat with an unknown ID.

Behaviour:
- Clocking/reset: one clock, clk_i; rst_i is synchronous, active-high.
- On reset:
  - rr_ptr=0, lock=0, lock_idx=0.
  - All ID table entries invalid, all counts 0; err_o=0.
  - Every valid/ready output deasserts combinationally, since it derives from the cleared state.
- ID table: 2**IdWidth entries, each {valid, owner[clog2(NumMst)], cnt[clog2(MaxTxn+1)]}.
- Eligibility: requester m is eligible when mst_ar_valid_i[m]=1 and the entry at its id is either invalid, or valid with owner==m and cnt<MaxTxn.
- Arbitration (two states):
  - IDLE:
    - Pick the first eligible requester at or after rr_ptr, cyclically.
    - slv_ar_o = that payload plus nsaid_cfg_i[m]; slv_ar_valid_o=1. Latency from valid to slave: 0 cycles.
    - If slv_ar_ready_i=1: handshake completes; mst_ar_ready_o[m]=1; rr_ptr<=(m+1) mod NumMst; stay in IDLE.
    - Otherwise: lock<=1, lock_idx<=m, NSAID registered; go to LOCKED.
  - LOCKED:
    - Output is held on lock_idx with the registered NSAID, regardless of eligibility changes or nsaid_cfg_i changes. This meets the AXI rule that valid, once raised, is not withdrawn.
    - On slv_ar_ready_i=1: handshake; rr_ptr advances past lock_idx; back to IDLE.
- mst_ar_ready_o[k]=0 for every k that was not granted.
- On an AR handshake: entry[id] becomes valid, owner<=m, cnt+=1.
- R routing:
  - If slv_r_valid_i=1 and entry[slv_r_i.id] is valid: mst_r_valid_o[owner]=1 and slv_r_ready_o=mst_r_ready_i[owner].
  - On a handshake with last=1: cnt-=1. When cnt reaches 0, valid<=0.
  - If the entry is invalid: slv_r_ready_o=1, the beat is dropped, no requester valid is raised, and err_o<=1 (sticky until reset).
- Same-cycle AR handshake and R last on the same ID: cnt stays unchanged and the entry stays valid.
- A requester never sees its own ID blocked by another requester's in-flight transactions once that ID has fully drained.
- Full: cnt==MaxTxn makes that ID ineligible, including for its owner, until a last beat arrives.
- Reset mid-transaction: the table is cleared. R beats the slave returns afterwards for pre-reset ARs set err_o.

Optional Feature:
- Macro: AXI_RD_ARB_PERF_EN.
- When defined, adds output perf_stall_o (NumMst x CntWidth):
  - Per-requester saturating count of cycles with mst_ar_valid_i=1 and mst_ar_ready_o=0.
  - Cleared by rst_i; holds at all-ones once saturated.
- When undefined: no port, no counters.

Test Plan:
- Requesters 0..3 all hold valid with IDs 0..3; slave ready=1 → grants 0,1,2,3,0 on consecutive cycles; slv_ar_o.nsaid equals each requester's nsaid_cfg_i.
- Requester 2 valid, slave ready=0 for 3 cycles while requester 1 raises valid → slv_ar_o stable on requester 2 for all 4 cycles; grant goes to 2 at the ready cycle, then 1 on the next cycle.
- Requester 0 has 1 read on id=5 in flight; requester 1 issues id=5 → requester 1 stalls until the slave returns R last id=5; then it is granted; both R bursts arrive at the correct requester.
- 8 ARs with id=3 from requester 0, no R returned → 9th not granted; one R last id=3 → 9th granted the next cycle.
- Slave R with id=7 and no in-flight id=7 → slv_r_ready_o=1, no mst_r_valid_o, err_o=1 and stays set; rst_i pulse → err_o=0.
- rst_i asserted while 2 reads are in flight → all outputs deasserted, table empty; with AXI_RD_ARB_PERF_EN, a requester blocked 10 cycles reads perf_stall_o=10.
